// File: rtl/noc_pkg.sv
// Shared definitions for the 9-bit flit network: flit geometry and the
// holding-register states of the merge stage.
package noc_pkg;

   localparam int unsigned FLIT_W  = 9;
   localparam int unsigned ADDR_HI = 8;
   localparam int unsigned ADDR_LO = 5;

   typedef logic [FLIT_W-1:0] flit_t;

   typedef enum logic [1:0] {
      EMPTY     = 2'b00,
      BOTH      = 2'b11,
      DATA_ONLY = 2'b10,
      WIN_ONLY  = 2'b01
   } merge_st_e;

endpackage : noc_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant index plus the registered
// pointer to the last winner, advanced only when a grant is actually used.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_update,
   output logic o_grant
);

   logic r_last;

   always_comb begin
      o_grant = 1'b0;
      if (i_req0 && i_req1) begin
         o_grant = ~r_last;
      end else if (i_req1) begin
         o_grant = 1'b1;
      end
   end

   // Reset to 1 so input 0 wins the first contention.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= 1'b1;
      end else if (i_update) begin
         r_last <= o_grant;
      end
   end

endmodule : rr_arb2

// File: rtl/arbiter_merge.sv
// Round-robin merge of two flit streams into one output channel, with the
// winning input index released on an independent token side channel.
module arbiter_merge
   import noc_pkg::*;
#(
   parameter int unsigned WIDTH = FLIT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   input  logic [WIDTH-1:0] in1_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             win_valid,
   input  logic             win_ready,
   output logic             win
);

   merge_st_e        r_state;
   merge_st_e        w_state_nxt;
   logic [WIDTH-1:0] r_data;
   logic             r_win;
   logic             w_dp;
   logic             w_wp;
   logic             w_dtake;
   logic             w_wtake;
   logic             w_free;
   logic             w_grant;
   logic             w_load;

   assign w_dp    = (r_state == BOTH) || (r_state == DATA_ONLY);
   assign w_wp    = (r_state == BOTH) || (r_state == WIN_ONLY);
   assign w_dtake = w_dp && out_ready;
   assign w_wtake = w_wp && win_ready;

   // Free when nothing remains pending after this cycle's takes; blocked in reset.
   assign w_free = !reset && (!w_dp || w_dtake) && (!w_wp || w_wtake);

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .i_req0   (in0_valid),
      .i_req1   (in1_valid),
      .i_update (w_load),
      .o_grant  (w_grant)
   );

   assign in0_ready = w_free && in0_valid && !w_grant;
   assign in1_ready = w_free && in1_valid &&  w_grant;
   assign w_load    = in0_ready || in1_ready;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: begin
            if (w_load) w_state_nxt = BOTH;
         end
         BOTH: begin
            if (w_dtake && w_wtake) begin
               w_state_nxt = w_load ? BOTH : EMPTY;
            end else if (w_dtake) begin
               w_state_nxt = WIN_ONLY;
            end else if (w_wtake) begin
               w_state_nxt = DATA_ONLY;
            end
         end
         DATA_ONLY: begin
            if (w_dtake) w_state_nxt = w_load ? BOTH : EMPTY;
         end
         WIN_ONLY: begin
            if (w_wtake) w_state_nxt = w_load ? BOTH : EMPTY;
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_data  <= '0;
         r_win   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_data <= w_grant ? in1_data : in0_data;
            r_win  <= w_grant;
         end
      end
   end

   assign out_valid = w_dp;
   assign win_valid = w_wp;
   assign out_data  = r_data;
   assign win       = r_win;

endmodule : arbiter_merge

// File: tb/tb_arbiter_merge.sv
// Directed and random stimulus for arbiter_merge, checked every cycle against
// a queue-based reference model of the flit and token channels.
module tb_arbiter_merge;

   logic       clk = 1'b0;
   logic       reset;
   logic       in0_valid, in0_ready, in1_valid, in1_ready;
   logic [8:0] in0_data, in1_data, out_data;
   logic       out_valid, out_ready, win_valid, win_ready, win;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: each channel is a queue holding at most one item.
   logic [8:0] qd[$];
   bit         qw[$];
   logic [8:0] m_lastd;
   bit         m_lastw;
   bit         m_last;
   bit         e_r0, e_r1, e_g, e_dt, e_wt;

   always #5 clk = ~clk;

   arbiter_merge #(.WIDTH(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win       (win)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      qd.delete();
      qw.delete();
      m_lastd = '0;
      m_lastw = 1'b0;
      m_last  = 1'b1;
   endtask

   // One clock cycle: check at the falling edge, advance the model at the rising edge.
   task automatic step(input string tag);
      bit free;
      logic [8:0] d;
      @(negedge clk);
      e_dt = (qd.size() > 0) && out_ready;
      e_wt = (qw.size() > 0) && win_ready;
      free = !reset && ((qd.size() == 0) || e_dt) && ((qw.size() == 0) || e_wt);
      e_g  = (in0_valid && in1_valid) ? !m_last : in1_valid;
      e_r0 = free && in0_valid && !e_g;
      e_r1 = free && in1_valid &&  e_g;
      check({tag, ".in0_ready"}, 32'(in0_ready), 32'(e_r0));
      check({tag, ".in1_ready"}, 32'(in1_ready), 32'(e_r1));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(qd.size() > 0));
      check({tag, ".win_valid"}, 32'(win_valid), 32'(qw.size() > 0));
      check({tag, ".out_data"},  32'(out_data),  32'(m_lastd));
      check({tag, ".win"},       32'(win),       32'(m_lastw));
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (e_dt) void'(qd.pop_front());
         if (e_wt) void'(qw.pop_front());
         if (e_r0 || e_r1) begin
            d = e_g ? in1_data : in0_data;
            qd.push_back(d);
            qw.push_back(e_g);
            m_lastd = d;
            m_lastw = e_g;
            m_last  = e_g;
         end
      end
      #1;
   endtask

   initial begin
      int k;
      int guard;
      reset = 1'b1;
      in0_valid = 1'b1; in0_data = 9'h1A0;
      in1_valid = 1'b1; in1_data = 9'h0F3;
      out_ready = 1'b1; win_ready = 1'b1;
      model_reset();
      @(posedge clk); #1;

      // Reset held with both inputs valid: nothing accepted, nothing valid.
      step("rst0");
      step("rst1");
      reset = 1'b0;

      // Continuous contention: grants alternate starting with in0.
      for (int i = 0; i < 8; i++) begin
         step("cont");
         if (i == 0) check("cont.first_grant0", 32'(qw.size() > 0 && qw[0] == 1'b0), 32'd1);
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      step("drain");
      step("drain");

      // Single source on in1: four flits back-to-back.
      k = 0; guard = 0;
      in1_valid = 1'b1;
      while (k < 4 && guard < 12) begin
         in1_data = 9'h101 + 9'(k);
         step("single");
         if (e_r1) k++;
         guard++;
      end
      check("single.accepted", 32'(k), 32'd4);
      check("single.cycles", 32'(guard), 32'd4);
      in1_valid = 1'b0;
      step("single_tail");

      // Split release: token taken, flit held for three cycles, then released.
      in0_valid = 1'b1; in0_data = 9'h0AA;
      out_ready = 1'b0; win_ready = 1'b1;
      step("split_load");
      in0_data = 9'h0BB;
      for (int i = 0; i < 3; i++) step("split_hold");
      check("split.flit_held", 32'(out_data), 32'h0AA);
      out_ready = 1'b1;
      step("split_release");
      check("split.reload_same_cycle", 32'(e_r0), 32'd1);
      in0_valid = 1'b0;
      step("split_tail");
      step("split_tail");

      // Reset mid-flight: a pending flit is discarded.
      in0_valid = 1'b1; in0_data = 9'h155;
      out_ready = 1'b0; win_ready = 1'b0;
      step("mid_load");
      in0_valid = 1'b0;
      step("mid_hold");
      reset = 1'b1;
      step("mid_reset");
      reset = 1'b0;
      out_ready = 1'b1; win_ready = 1'b1;
      step("mid_after");
      check("mid.dropped", 32'(out_valid), 32'd0);

      // Random traffic and back-pressure.
      for (int i = 0; i < 400; i++) begin
         in0_valid = 1'($urandom_range(0, 1));
         in1_valid = 1'($urandom_range(0, 1));
         in0_data  = 9'($urandom);
         in1_data  = 9'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         win_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 99) == 0);
         step("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_arbiter_merge
